// File: rtl/lfsr_scrambler_ser.sv
// Seed-load, scramble, then serialise LFSR.
// A start in IDLE loads the seed (zero seed is replaced by 1 to avoid LFSR
// lockup), the Fibonacci LFSR runs SCRAMBLE_CYCLES steps, the scrambled word
// is shifted out LSB-first under Valid, and a one-cycle done pulse closes
// the transaction.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start; all outputs low
// SCRAMBLE | LFSR stepping, counting SCRAMBLE_CYCLES steps
// SHIFT    | one payload bit per cycle on OUT with Valid high
// DONE     | first cycle raises done and drops busy, second returns to IDLE
module lfsr_scrambler_ser #(
    parameter int               WIDTH           = 4,
    parameter logic [WIDTH-1:0] TAPS            = 4'b0111,
    parameter int               SCRAMBLE_CYCLES = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [WIDTH-1:0] seed,
    output logic             OUT,
    output logic             Valid,
    output logic             busy,
    output logic             done
);

    // Counter must hold both the scramble step index and the bit index.
    localparam int CNT_MAX = (SCRAMBLE_CYCLES + 1 > WIDTH + 1) ? (SCRAMBLE_CYCLES + 1) : (WIDTH + 1);
    localparam int CNT_W   = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] SC_LAST    = (SCRAMBLE_CYCLES > 0) ? CNT_W'(SCRAMBLE_CYCLES - 1) : '0;
    localparam logic [CNT_W-1:0] SH_LAST    = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] SEED_GUARD = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_SCRAMBLE = 2'd1,
        S_SHIFT    = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_lfsr;
    logic [WIDTH-1:0]   w_lfsr_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_out;
    logic               w_out_nxt;
    logic               r_valid;
    logic               w_valid_nxt;
    logic               r_busy;
    logic               w_busy_nxt;
    logic               r_done;
    logic               w_done_nxt;
    logic               w_fb;

    assign w_fb = ^(r_lfsr & TAPS);

    // Next-state and next-output decode; outputs are registered below.
    always_comb begin
        w_state_nxt = r_state;
        w_lfsr_nxt  = r_lfsr;
        w_cnt_nxt   = r_cnt;
        w_out_nxt   = 1'b0;
        w_valid_nxt = 1'b0;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_busy_nxt = 1'b0;
                if (start) begin
                    w_lfsr_nxt  = (seed == '0) ? SEED_GUARD : seed;
                    w_cnt_nxt   = '0;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = (SCRAMBLE_CYCLES == 0) ? S_SHIFT : S_SCRAMBLE;
                end
            end

            S_SCRAMBLE: begin
                w_lfsr_nxt = {w_fb, r_lfsr[WIDTH-1:1]};
                if (r_cnt == SC_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_SHIFT;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end

            S_SHIFT: begin
                w_out_nxt   = r_lfsr[0];
                w_valid_nxt = 1'b1;
                w_lfsr_nxt  = r_lfsr >> 1;
                if (r_cnt == SH_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_DONE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end

            S_DONE: begin
                // r_done distinguishes the pulse cycle from the return cycle.
                w_busy_nxt = 1'b0;
                if (!r_done) begin
                    w_done_nxt = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_lfsr  <= '0;
            r_cnt   <= '0;
            r_out   <= 1'b0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_lfsr  <= w_lfsr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_out   <= w_out_nxt;
            r_valid <= w_valid_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign OUT   = r_out;
    assign Valid = r_valid;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule

// File: tb/tb_lfsr_scrambler_ser.sv
// Scoreboard bench for lfsr_scrambler_ser across three parameter sets.
module tb_lfsr_scrambler_ser;

    localparam int W_OF    [3] = '{4, 4, 8};
    localparam int SC_OF   [3] = '{4, 0, 255};
    localparam int TAPS_OF [3] = '{7, 7, 184};

    logic       clk = 1'b0;
    logic       rst_v   [3];
    logic       start_v [3];
    logic [3:0] seed_a;
    logic [3:0] seed_b;
    logic [7:0] seed_c;
    logic       out_v   [3];
    logic       valid_v [3];
    logic       busy_v  [3];
    logic       done_v  [3];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    bit exp_q [3][$];
    int bcnt [3];
    int vcnt [3];
    bit prev_valid [3];
    bit prev_done [3];
    int done_cnt [3];
    int last_done_cyc [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lfsr_scrambler_ser #(.WIDTH(4), .TAPS(4'b0111), .SCRAMBLE_CYCLES(4)) u_a (
        .CLK(clk), .RST(rst_v[0]), .start(start_v[0]), .seed(seed_a),
        .OUT(out_v[0]), .Valid(valid_v[0]), .busy(busy_v[0]), .done(done_v[0]));

    lfsr_scrambler_ser #(.WIDTH(4), .TAPS(4'b0111), .SCRAMBLE_CYCLES(0)) u_b (
        .CLK(clk), .RST(rst_v[1]), .start(start_v[1]), .seed(seed_b),
        .OUT(out_v[1]), .Valid(valid_v[1]), .busy(busy_v[1]), .done(done_v[1]));

    lfsr_scrambler_ser #(.WIDTH(8), .TAPS(8'hB8), .SCRAMBLE_CYCLES(255)) u_c (
        .CLK(clk), .RST(rst_v[2]), .start(start_v[2]), .seed(seed_c),
        .OUT(out_v[2]), .Valid(valid_v[2]), .busy(busy_v[2]), .done(done_v[2]));

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s dut%0d: got %0d expected %0d (t=%0t)", name, k, act, exp, $time);
        end
    endtask

    // Reference: scramble with integer arithmetic, then queue the word LSB first.
    function automatic void push_model(input int k, input int s);
        int w;
        int st;
        int fb;
        w  = W_OF[k];
        st = s & ((1 << w) - 1);
        if (st == 0) st = 1;
        for (int i = 0; i < SC_OF[k]; i++) begin
            fb = $countones(st & TAPS_OF[k]) & 1;
            st = (st >> 1) | (fb << (w - 1));
        end
        for (int i = 0; i < w; i++) exp_q[k].push_back(bit'((st >> i) & 1));
    endfunction

    task automatic set_seed(input int k, input int s);
        logic [31:0] v;
        v = s;
        case (k)
            0: seed_a = v[3:0];
            1: seed_b = v[3:0];
            default: seed_c = v[7:0];
        endcase
    endtask

    // Monitor: pops the scoreboard on every Valid bit and checks transaction framing.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst_v[k]) begin
                if (busy_v[k]) bcnt[k]++;
                if (valid_v[k]) begin
                    if (!prev_valid[k]) chk("first_bit_latency", k, bcnt[k], SC_OF[k] + 2);
                    chk("busy_while_valid", k, busy_v[k], 1);
                    if (exp_q[k].size() == 0) chk("unexpected_bit", k, 1, 0);
                    else chk("serial_bit", k, out_v[k], exp_q[k].pop_front());
                    vcnt[k]++;
                end
                if (done_v[k]) begin
                    chk("done_single_cycle", k, prev_done[k], 0);
                    chk("busy_length", k, bcnt[k], SC_OF[k] + W_OF[k] + 1);
                    chk("valid_length", k, vcnt[k], W_OF[k]);
                    chk("busy_low_at_done", k, busy_v[k], 0);
                    chk("idle_out_at_done", k, {out_v[k], valid_v[k]}, 0);
                    done_cnt[k]++;
                    last_done_cyc[k] = cyc;
                    bcnt[k] = 0;
                    vcnt[k] = 0;
                end
                prev_valid[k] = valid_v[k];
                prev_done[k]  = done_v[k];
            end
        end
    end

    task automatic wait_done(input int k, input int budget);
        bit seen;
        seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done_v[k]) seen = 1;
        end
        if (!seen) chk("done_timeout", k, 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic run_txn(input int k, input int s, input bit use_model, input bit extra);
        set_seed(k, s);
        start_v[k] = 1'b1;
        if (use_model) push_model(k, s);
        @(posedge clk); #1;
        start_v[k] = 1'b0;
        set_seed(k, int'($urandom));
        if (extra) begin
            for (int c = 1; c < SC_OF[k] + W_OF[k]; c++) begin
                start_v[k] = ($urandom_range(0, 3) == 0);
                set_seed(k, int'($urandom));
                @(posedge clk); #1;
            end
            start_v[k] = 1'b0;
        end
        wait_done(k, SC_OF[k] + W_OF[k] + 20);
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    endtask

    initial begin
        int d0;
        int gap;
        bit seen;
        for (int k = 0; k < 3; k++) begin
            rst_v[k] = 1'b1; start_v[k] = 1'b0;
            bcnt[k] = 0; vcnt[k] = 0; prev_valid[k] = 0; prev_done[k] = 0;
            done_cnt[k] = 0; last_done_cyc[k] = 0;
        end
        seed_a = 4'h0; seed_b = 4'h0; seed_c = 8'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("reset_out", k, out_v[k], 0);
            chk("reset_valid", k, valid_v[k], 0);
            chk("reset_busy", k, busy_v[k], 0);
            chk("reset_done", k, done_v[k], 0);
        end
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) rst_v[k] = 1'b0;
        repeat (2) begin @(posedge clk); #1; end

        // Directed: seed 1001 -> 1,1,0,1
        exp_q[0].push_back(1); exp_q[0].push_back(1); exp_q[0].push_back(0); exp_q[0].push_back(1);
        run_txn(0, 9, 0, 0);
        // Directed: zero seed guarded to 0001 -> 1,0,1,1 (extra starts while busy)
        exp_q[0].push_back(1); exp_q[0].push_back(0); exp_q[0].push_back(1); exp_q[0].push_back(1);
        run_txn(0, 0, 0, 1);
        // Directed: no scramble, seed 0110 -> 0,1,1,0
        exp_q[1].push_back(0); exp_q[1].push_back(1); exp_q[1].push_back(1); exp_q[1].push_back(0);
        run_txn(1, 6, 0, 0);

        // start held high: one transaction per IDLE visit, restart two cycles after done
        d0 = done_cnt[1];
        set_seed(1, 5);
        push_model(1, 5);
        push_model(1, 5);
        start_v[1] = 1'b1;
        wait_done(1, 30);
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (busy_v[1]) seen = 1;
        end
        gap = cyc - last_done_cyc[1];
        chk("restart_seen", 1, seen, 1);
        chk("restart_gap", 1, gap, 2);
        @(posedge clk); #1;
        start_v[1] = 1'b0;
        wait_done(1, 30);
        repeat (4) begin @(posedge clk); #1; end
        chk("held_start_txn_count", 1, done_cnt[1] - d0, 2);

        // Abort during SHIFT after two bits: outputs clear, no done pulse
        set_seed(0, 10);
        push_model(0, 10);
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        repeat (SC_OF[0] + 2) begin @(posedge clk); #1; end
        rst_v[0] = 1'b1;
        @(posedge clk); #1;
        exp_q[0].delete();
        bcnt[0] = 0; vcnt[0] = 0; prev_valid[0] = 0; prev_done[0] = 0;
        d0 = done_cnt[0];
        @(negedge clk);
        chk("abort_out", 0, out_v[0], 0);
        chk("abort_valid", 0, valid_v[0], 0);
        chk("abort_busy", 0, busy_v[0], 0);
        chk("abort_done", 0, done_v[0], 0);
        @(posedge clk); #1;
        rst_v[0] = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        chk("abort_no_done", 0, done_cnt[0] - d0, 0);
        run_txn(0, 3, 1, 0);

        // Randomised transactions against the reference model
        for (int n = 0; n < 10; n++) run_txn(0, int'($urandom_range(0, 15)), 1, 1);
        for (int n = 0; n < 10; n++) run_txn(1, int'($urandom_range(0, 15)), 1, 1);
        run_txn(2, 0, 1, 0);
        for (int n = 0; n < 5; n++) run_txn(2, int'($urandom_range(0, 255)), 1, n[0]);

        repeat (5) begin @(posedge clk); #1; end
        for (int k = 0; k < 3; k++) chk("scoreboard_drained", k, exp_q[k].size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
